adder_checker: RTL and testbench

ADDER_CHECKER -- requirements
Module: adder_checker

---
 rtl/adder_checker.sv | 155 +++++++++++++++
 tb/tb_adder_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_checker.sv
//==============================================================================
// Module      : adder_checker
// Description : LFSR-driven self-test sequencer for an external 8-bit adder.
//               Applies pseudo-random vectors, waits SETTLE cycles, then
//               judges {cout,sum} against an ideal 9-bit sum.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module adder_checker #(
    parameter int          NUM_VECTORS = 64,       // legal 1..255
    parameter int          SETTLE      = 1,        // legal 1..15
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [7:0]  a,
    output logic [7:0]  b,
    output logic        cin,
    input  logic [7:0]  sum,
    input  logic        cout,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [7:0]  fail_idx,
    output logic [16:0] fail_vec
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] C_SEED     = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [7:0]  C_LAST_IDX = 8'(NUM_VECTORS - 1);
    localparam logic [3:0]  C_SETTLE   = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t       r_state;
    logic [15:0]  r_lfsr;
    logic [7:0]   r_index;
    logic [3:0]   r_settle_cnt;
    logic [7:0]   r_a;
    logic [7:0]   r_b;
    logic         r_cin;
    logic         r_busy;
    logic         r_done;
    logic [7:0]   r_err_count;
    logic [7:0]   r_fail_idx;
    logic [16:0]  r_fail_vec;

    logic         w_feedback;
    logic [15:0]  w_lfsr_next;
    logic [8:0]   w_expected;
    logic         w_mismatch;

    assign w_feedback  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_lfsr_next = {r_lfsr[14:0], w_feedback};

    // The operand registers mirror the LFSR, so the reference sum uses them directly.
    assign w_expected = {1'b0, r_a} + {1'b0, r_b} + {8'b0, r_cin};
    assign w_mismatch = ({cout, sum} != w_expected);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_lfsr       <= C_SEED;
            r_index      <= 8'd0;
            r_settle_cnt <= 4'd0;
            r_a          <= 8'd0;
            r_b          <= 8'd0;
            r_cin        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err_count  <= 8'd0;
            r_fail_idx   <= 8'd0;
            r_fail_vec   <= 17'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_WAIT;
                        r_lfsr       <= C_SEED;
                        r_index      <= 8'd0;
                        r_settle_cnt <= C_SETTLE;
                        r_a          <= C_SEED[7:0];
                        r_b          <= C_SEED[15:8];
                        r_cin        <= C_SEED[3];
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_err_count  <= 8'd0;
                        r_fail_idx   <= 8'd0;
                        r_fail_vec   <= 17'd0;
                    end
                end

                S_WAIT: begin
                    r_settle_cnt <= r_settle_cnt - 4'd1;
                    if (r_settle_cnt == 4'd1) begin
                        r_state <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (w_mismatch) begin
                        if (r_err_count != 8'hFF) begin
                            r_err_count <= r_err_count + 8'd1;
                        end
                        if (r_err_count == 8'd0) begin
                            r_fail_idx <= r_index;
                            r_fail_vec <= {r_a, r_b, r_cin};
                        end
                    end
                    r_lfsr  <= w_lfsr_next;
                    r_index <= r_index + 8'd1;
                    if (r_index == C_LAST_IDX) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_a     <= 8'd0;
                        r_b     <= 8'd0;
                        r_cin   <= 1'b0;
                    end else begin
                        r_state      <= S_WAIT;
                        r_settle_cnt <= C_SETTLE;
                        r_a          <= w_lfsr_next[7:0];
                        r_b          <= w_lfsr_next[15:8];
                        r_cin        <= w_lfsr_next[3];
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign a         = r_a;
    assign b         = r_b;
    assign cin       = r_cin;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_done && (r_err_count == 8'd0);
    assign err_count = r_err_count;
    assign fail_idx  = r_fail_idx;
    assign fail_vec  = r_fail_vec;

endmodule

`default_nettype wire

// File: tb/tb_adder_checker.sv
//==============================================================================
// Module      : tb_adder_checker
// Description : Directed bench for adder_checker with three instances and
//               behavioural adder models (ideal, faulty, pipelined).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_adder_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start_w   [3];
    logic [7:0]  a_w       [3];
    logic [7:0]  b_w       [3];
    logic        cin_w     [3];
    logic [7:0]  sum_w     [3];
    logic        cout_w    [3];
    logic        busy_w    [3];
    logic        done_w    [3];
    logic        pass_w    [3];
    logic [7:0]  err_w     [3];
    logic [7:0]  fidx_w    [3];
    logic [16:0] fvec_w    [3];

    int n_tests = 0;
    int n_fail  = 0;
    int mode0;

    logic [8:0] ideal   [3];
    logic [8:0] pipe0_1, pipe0_2, pipe2_1, pipe2_2;
    logic [16:0] c_first_vec;

    // DUT0: default parameters, model selectable through mode0
    adder_checker u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start_w[0]),
        .a(a_w[0]), .b(b_w[0]), .cin(cin_w[0]), .sum(sum_w[0]), .cout(cout_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(err_w[0]), .fail_idx(fidx_w[0]), .fail_vec(fvec_w[0])
    );

    // DUT1: longest run against an always-wrong adder
    adder_checker #(.NUM_VECTORS(255)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start_w[1]),
        .a(a_w[1]), .b(b_w[1]), .cin(cin_w[1]), .sum(sum_w[1]), .cout(cout_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(err_w[1]), .fail_idx(fidx_w[1]), .fail_vec(fvec_w[1])
    );

    // DUT2: longer settle time against a 2-cycle-latency adder
    adder_checker #(.SETTLE(3)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start_w[2]),
        .a(a_w[2]), .b(b_w[2]), .cin(cin_w[2]), .sum(sum_w[2]), .cout(cout_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_count(err_w[2]), .fail_idx(fidx_w[2]), .fail_vec(fvec_w[2])
    );

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            ideal[i] = {1'b0, a_w[i]} + {1'b0, b_w[i]} + {8'b0, cin_w[i]};
        end
    end

    always @(posedge clk) begin
        pipe0_1 <= ideal[0];
        pipe0_2 <= pipe0_1;
        pipe2_1 <= ideal[2];
        pipe2_2 <= pipe2_1;
    end

    always_comb begin
        {cout_w[0], sum_w[0]} = ideal[0];
        if (mode0 == 1) {cout_w[0], sum_w[0]} = ideal[0] ^ 9'h001;
        if (mode0 == 3) {cout_w[0], sum_w[0]} = pipe0_2;
        {cout_w[1], sum_w[1]} = ideal[1] + 9'd1;
        {cout_w[2], sum_w[2]} = pipe2_2;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Starts a run on DUT d; edges counts rising edges after the START-sampling edge.
    task automatic run(input int d, input bit hold, input int pulse_at, input int limit,
                       output int edges, output bit done_at0, output logic [16:0] first_vec);
        edges = 0;
        @(negedge clk);
        start_w[d] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start_w[d] = 1'b0;
        done_at0  = done_w[d];
        first_vec = {a_w[d], b_w[d], cin_w[d]};
        while (edges < limit) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == pulse_at) start_w[d] = 1'b1;
            if (edges == pulse_at + 1 && !hold) start_w[d] = 1'b0;
            if (done_w[d]) break;
        end
        start_w[d] = 1'b0;
        check("run_done_in_budget", int'(done_w[d]), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          edges;
        bit          d0;
        logic [16:0] fv;

        c_first_vec = {8'hE1, 8'hAC, 1'b0};
        mode0   = 0;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) start_w[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy_w[0]), 0);
        check("rst_done", int'(done_w[0]), 0);
        check("rst_pass", int'(pass_w[0]), 0);
        check("rst_ab",   int'({a_w[0], b_w[0], cin_w[0]}), 0);
        check("rst_err",  int'(err_w[0]), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Ideal adder
        run(0, 0, -1, 400, edges, d0, fv);
        check("ideal_edges",  edges, 128);
        check("ideal_pass",   int'(pass_w[0]), 1);
        check("ideal_err",    int'(err_w[0]), 0);
        check("ideal_first",  int'(fv), int'(c_first_vec));
        check("ideal_busy",   int'(busy_w[0]), 0);
        check("idle_a_zero",  int'(a_w[0]), 0);

        // SUM[0] inverted
        mode0 = 1;
        run(0, 0, -1, 400, edges, d0, fv);
        check("inv_edges",   edges, 128);
        check("inv_err",     int'(err_w[0]), 64);
        check("inv_fidx",    int'(fidx_w[0]), 0);
        check("inv_fvec",    int'(fvec_w[0]), int'(c_first_vec));
        check("inv_pass",    int'(pass_w[0]), 0);
        repeat (5) @(posedge clk);
        #1;
        check("inv_hold_done", int'(done_w[0]), 1);
        check("inv_hold_err",  int'(err_w[0]), 64);

        // START held high, then START pulsed mid-run, then restart from DONE
        mode0 = 0;
        run(0, 1, -1, 400, edges, d0, fv);
        check("hold_clear_done", int'(d0), 0);
        check("hold_edges",      edges, 128);
        check("hold_pass",       int'(pass_w[0]), 1);
        run(0, 0, 10, 400, edges, d0, fv);
        check("pulse_edges",     edges, 128);
        run(0, 0, -1, 400, edges, d0, fv);
        check("restart_clear",   int'(d0), 0);
        check("restart_first",   int'(fv), int'(c_first_vec));
        check("restart_edges",   edges, 128);
        check("restart_pass",    int'(pass_w[0]), 1);

        // Reset mid-run discards partial results
        mode0 = 1;
        @(negedge clk);
        start_w[0] = 1'b1;
        @(posedge clk);
        #1;
        start_w[0] = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("midrun_err", int'(err_w[0]), 25);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", int'(busy_w[0]), 0);
        check("arst_err",  int'(err_w[0]), 0);
        check("arst_fvec", int'(fvec_w[0]), 0);
        check("arst_ab",   int'({a_w[0], b_w[0], cin_w[0]}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_busy", int'(busy_w[0]), 0);
        check("post_rst_done", int'(done_w[0]), 0);
        mode0 = 0;
        run(0, 0, -1, 400, edges, d0, fv);
        check("post_rst_edges", edges, 128);
        check("post_rst_pass",  int'(pass_w[0]), 1);
        check("post_rst_first", int'(fv), int'(c_first_vec));

        // Saturation at 255
        run(1, 0, -1, 700, edges, d0, fv);
        check("sat_edges", edges, 510);
        check("sat_err",   int'(err_w[1]), 255);
        check("sat_pass",  int'(pass_w[1]), 0);

        // Pipelined adder: SETTLE=3 passes, SETTLE=1 does not
        run(2, 0, -1, 400, edges, d0, fv);
        check("lat3_edges", edges, 256);
        check("lat3_pass",  int'(pass_w[2]), 1);
        mode0 = 3;
        run(0, 0, -1, 400, edges, d0, fv);
        check("lat1_err_nz", int'(err_w[0] != 8'd0), 1);
        check("lat1_pass",   int'(pass_w[0]), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
